mem_bank_responder: RTL and testbench

Slave-side responder for one interconnect slave port: accepts `req`/`addr`/`we`/`be`/`wdata` from the interconnect, answers with `gnt`, then `rvalid`/`rdata`. Holds a word-organised on-chip memory bank with byte-enable writes and a configurable number of wait states. One instance sits behind each slave port of the master/slave interconnect.

---
 rtl/mem_bank_responder.sv | 159 +++++++++++++++
 tb/tb_mem_bank_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_responder.sv
// Slave-port responder: word-organised memory bank with byte-enable writes and WAIT_STATES cycles before gnt.
// Optional MEM_BANK_INIT_EN: after reset, clear every word (one per cycle) before accepting requests.
module mem_bank_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    gnt,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDX_W = ADDR_WIDTH - OFFS;
  localparam int DEPTH = 1 << IDX_W;

`ifdef MEM_BANK_INIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INIT} state_t;
  localparam state_t RESET_STATE = S_INIT;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT} state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_wcnt;
  logic [3:0]            w_wcnt_next;
  logic                  w_gnt;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_unused_addr;

`ifdef MEM_BANK_INIT_EN
  logic [IDX_W-1:0]      r_init_idx;
  logic                  w_init_wr;
`endif

  // Word index wraps naturally by truncation; sub-word address bits are ignored.
  assign w_idx = addr[ADDR_WIDTH-1:OFFS];

  generate
    if (OFFS > 0) begin : g_low_bits
      assign w_unused_addr = ^addr[OFFS-1:0];
    end else begin : g_no_low_bits
      assign w_unused_addr = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_gnt        = 1'b0;
`ifdef MEM_BANK_INIT_EN
    w_init_wr    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            w_gnt = 1'b1;
          end else begin
            w_state_next = S_WAIT;
            w_wcnt_next  = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          w_state_next = S_IDLE;
          w_wcnt_next  = '0;
        end else begin
          w_wcnt_next = r_wcnt - 4'd1;
          if (r_wcnt == 4'd1) begin
            w_gnt        = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
`ifdef MEM_BANK_INIT_EN
      S_INIT: begin
        w_init_wr = 1'b1;
        if (r_init_idx == '1) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: w_state_next = RESET_STATE;
    endcase
    // Reset suppresses a grant due this cycle, so its response is never issued.
    if (rst) begin
      w_gnt        = 1'b0;
      w_state_next = RESET_STATE;
      w_wcnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RESET_STATE;
      r_wcnt   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_wcnt   <= w_wcnt_next;
      r_rvalid <= w_gnt;
    end
  end

`ifdef MEM_BANK_INIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_idx <= '0;
    end else if (r_state == S_INIT) begin
      r_init_idx <= r_init_idx + IDX_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
`ifdef MEM_BANK_INIT_EN
    if (w_init_wr) begin
      r_mem[r_init_idx] <= '0;
    end else
`endif
    if (w_gnt && we) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be[k]) begin
          r_mem[w_idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_gnt) begin
      r_rdata <= we ? '0 : r_mem[w_idx];
    end
  end

  assign gnt    = w_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bank_responder.sv
// Scoreboard bench for mem_bank_responder: one instance with no wait states, one with three.
// Responses are predicted from a plain array model of each bank and checked by a monitor.
module tb_mem_bank_responder;

  logic        clk;
  logic        rst;
  logic        req0, req3;
  logic        we;
  logic [9:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt0, rvalid0, busy0;
  logic        gnt3, rvalid3, busy3;
  logic [31:0] rdata0, rdata3;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl0 [256];
  logic [31:0] mdl3 [256];
  logic [31:0] exp0_q [$];
  logic [31:0] exp3_q [$];
  bit          gprev0, gprev3;

`ifdef MEM_BANK_INIT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  mem_bank_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0), .busy(busy0)
  );

  mem_bank_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .req(req3), .addr(addr), .we(we), .be(be), .wdata(wdata),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Bank model: word index is the byte address divided by four, modulo 256.
  function automatic void model_tx(input int inst, input bit w, input logic [9:0] a,
                                   input logic [3:0] b, input logic [31:0] d);
    int idx;
    idx = (int'(a) / 4) % 256;
    if (inst == 0) begin
      if (w) begin
        mdl0[idx] = merge(mdl0[idx], d, b);
        exp0_q.push_back(32'h0);
      end else exp0_q.push_back(mdl0[idx]);
    end else begin
      if (w) begin
        mdl3[idx] = merge(mdl3[idx], d, b);
        exp3_q.push_back(32'h0);
      end else exp3_q.push_back(mdl3[idx]);
    end
  endfunction

  function automatic void clear_models();
    for (int i = 0; i < 256; i++) begin
      mdl0[i] = 32'h0;
      mdl3[i] = 32'h0;
    end
  endfunction

  // Monitor: pops an expected response for every rvalid and checks gnt-to-rvalid latency.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      gprev0 = 1'b0;
      gprev3 = 1'b0;
    end else begin
      if (rvalid0 || gprev0) chk("ws0_rvalid_latency", rvalid0, gprev0);
      if (rvalid0) begin
        if (exp0_q.size() == 0) chk("ws0_unexpected_rvalid", rvalid0, 0);
        else begin
          e = exp0_q.pop_front();
          $display("ws0 resp rdata=0x%08h expected=0x%08h", rdata0, e);
          chk("ws0_rdata", rdata0, e);
        end
      end
      if (rvalid3 || gprev3) chk("ws3_rvalid_latency", rvalid3, gprev3);
      if (rvalid3) begin
        if (exp3_q.size() == 0) chk("ws3_unexpected_rvalid", rvalid3, 0);
        else begin
          e = exp3_q.pop_front();
          $display("ws3 resp rdata=0x%08h expected=0x%08h", rdata3, e);
          chk("ws3_rdata", rdata3, e);
        end
      end
      if (!req0) chk("ws0_gnt_without_req", gnt0, 0);
      if (!req3) chk("ws3_gnt_without_req", gnt3, 0);
      gprev0 = gnt0;
      gprev3 = gnt3;
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic tx0(input bit w, input logic [9:0] a, input logic [3:0] b,
                     input logic [31:0] d, input bit last);
    req0 = 1'b1; we = w; addr = a; be = b; wdata = d;
    model_tx(0, w, a, b, d);
    @(negedge clk);
    chk("ws0_gnt", gnt0, 1);
    @(posedge clk); #1;
    if (last) req0 = 1'b0;
  endtask

  task automatic tx3(input bit w, input logic [9:0] a, input logic [3:0] b,
                     input logic [31:0] d);
    int n;
    req3 = 1'b1; we = w; addr = a; be = b; wdata = d;
    model_tx(3, w, a, b, d);
    n = 0;
    @(negedge clk);
    while (!gnt3 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("ws3_gnt_delay", 32'(n), 32'd3);
    @(posedge clk); #1;
    req3 = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy0 || busy3) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("ready_after_reset", {31'b0, busy0 | busy3}, 0);
    @(posedge clk); #1;
  endtask

  task automatic rst_in_wait(input int k);
    req3 = 1'b1; we = 1'b0; addr = 10'h040; be = 4'h0; wdata = 32'h0;
    repeat (k) begin
      @(negedge clk);
      chk("ws3_gnt_before_rst", gnt3, 0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ws3_gnt_during_rst", gnt3, 0);
    @(posedge clk); #1;
    rst = 1'b0; req3 = 1'b0;
`ifdef MEM_BANK_INIT_EN
    clear_models();
`endif
    @(negedge clk);
    chk("rst_ws3_gnt", gnt3, 0);
    chk("rst_ws3_rvalid", rvalid3, 0);
    chk("rst_ws3_rdata", rdata3, 0);
    chk("rst_ws3_busy", busy3, BUSY_RST);
    chk("rst_ws0_rvalid", rvalid0, 0);
    chk("rst_ws0_rdata", rdata0, 0);
    wait_ready();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req3 = 1'b0; we = 1'b0;
    addr = '0; be = '0; wdata = '0;
    clear_models();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt0", gnt0, 0);
    chk("reset_rvalid0", rvalid0, 0);
    chk("reset_rdata0", rdata0, 0);
    chk("reset_busy0", busy0, BUSY_RST);
    chk("reset_gnt3", gnt3, 0);
    chk("reset_rvalid3", rvalid3, 0);
    chk("reset_rdata3", rdata3, 0);
    chk("reset_busy3", busy3, BUSY_RST);
    wait_ready();

    // Byte-enable write, partial write, read-after-write with req held.
    tx0(1'b1, 10'h010, 4'b1111, 32'hDEADBEEF, 1'b0);
    tx0(1'b1, 10'h010, 4'b0010, 32'h00005500, 1'b0);
    tx0(1'b0, 10'h010, 4'b0000, 32'h0, 1'b1);
    // be = 0 still responds and changes nothing.
    tx0(1'b1, 10'h010, 4'b0000, 32'hFFFFFFFF, 1'b0);
    tx0(1'b0, 10'h010, 4'b0000, 32'h0, 1'b1);
    // Four back-to-back transactions.
    tx0(1'b1, 10'h000, 4'hF, 32'hA1A1A1A1, 1'b0);
    tx0(1'b1, 10'h004, 4'hF, 32'hB2B2B2B2, 1'b0);
    tx0(1'b0, 10'h000, 4'h0, 32'h0, 1'b0);
    tx0(1'b0, 10'h004, 4'h0, 32'h0, 1'b1);
    // Top word, low address bits ignored, word 0 separately.
    tx0(1'b1, 10'h3FC, 4'hF, 32'hC0FFEE01, 1'b1);
    tx0(1'b0, 10'h3FD, 4'h0, 32'h0, 1'b1);
    tx0(1'b1, 10'h000, 4'hF, 32'h12345678, 1'b0);
    tx0(1'b0, 10'h000, 4'h0, 32'h0, 1'b0);
    tx0(1'b0, 10'h3FE, 4'h0, 32'h0, 1'b1);

    // Randomized traffic on 16 prefilled words.
    for (int i = 0; i < 16; i++) tx0(1'b1, 10'(i * 4), 4'hF, $urandom, i == 15);
    for (int i = 0; i < 80; i++) begin
      bit last;
      last = (i == 79) || ($urandom_range(0, 2) == 0);
      tx0(1'($urandom), 10'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
          4'($urandom), $urandom, last);
      if (last) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Wait-state instance: write then read held back-to-back.
    tx3(1'b1, 10'h040, 4'hF, 32'h11223344);
    tx3(1'b0, 10'h040, 4'h0, 32'h0);

    // Abort: req for one cycle only.
    req3 = 1'b1; we = 1'b0; addr = 10'h040;
    @(negedge clk);
    chk("abort_busy_idle", busy3, 0);
    chk("abort_gnt_c0", gnt3, 0);
    @(posedge clk); #1;
    req3 = 1'b0;
    @(negedge clk);
    chk("abort_busy_wait", busy3, 1);
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_gnt", gnt3, 0);
    end
    chk("abort_back_to_idle", busy3, 0);
    @(posedge clk); #1;
    tx3(1'b0, 10'h040, 4'h0, 32'h0);

    // Reset during the second and third wait cycles.
    rst_in_wait(2);
    rst_in_wait(3);
    tx3(1'b0, 10'h041, 4'h0, 32'h0);

    // Randomized traffic on the wait-state instance.
    for (int i = 0; i < 4; i++) tx3(1'b1, 10'(80 + i * 4), 4'hF, $urandom);
    for (int i = 0; i < 12; i++)
      tx3(1'($urandom), 10'(80 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3)),
          4'($urandom), $urandom);

`ifdef MEM_BANK_INIT_EN
    begin
      int n;
      tx0(1'b1, 10'h01C, 4'hF, 32'h00000055, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_models();
      req0 = 1'b1; we = 1'b0; addr = 10'h01C; be = 4'h0;
      model_tx(0, 1'b0, 10'h01C, 4'h0, 32'h0);
      n = 0;
      @(negedge clk);
      while (busy0 && n < 400) begin
        if (gnt0) chk("init_gnt_while_busy", gnt0, 0);
        n++;
        @(negedge clk);
      end
      chk("init_busy_cycles", 32'(n), 32'd256);
      chk("init_gnt_after", gnt0, 1);
      @(posedge clk); #1;
      req0 = 1'b0;
    end
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("ws0_pending_responses", 32'(exp0_q.size()), 0);
    chk("ws3_pending_responses", 32'(exp3_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
